rt_commit_unit: RTL
===================

# rt_commit_unit

Retire-side consumer of the reorder buffer's per-cycle retire packets (up to 3, slot 2 oldest). Commits retired instructions to architectural state in program order: architectural map table writes, physical-register free-list returns and store-queue commit counts. Detects retiring mispredicted branches and halts, truncates younger same-cycle retirements, and drives the registered pipeline-recovery pulse and redirect PC back to fetch, the ROB and the LSQ.

## Interface
Parameters:
- AREG_W, 5, architectural register index width
- PREG_W, 6, physical register tag width
- XLEN, 32, PC width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ret_valid  in  [2:0]  retire slot valid; slot 2 oldest, then 1, then 0
- ret_areg  in  [2:0][AREG_W-1:0]  destination architectural register
- ret_tag  in  [2:0][PREG_W-1:0]  new physical register
- ret_told  in  [2:0][PREG_W-1:0]  previous physical mapping
- ret_is_store  in  [2:0]  slot is a store
- ret_halt  in  [2:0]  slot is a halt
- ret_precise  in  [2:0]  mispredict; recovery required
- ret_target  in  [2:0][XLEN-1:0]  correct redirect PC
- am_we  out  [2:0]  arch map write enable per slot
- am_areg  out  [2:0][AREG_W-1:0]  arch map write index
- am_preg  out  [2:0][PREG_W-1:0]  arch map write data
- fl_ret_valid  out  [2:0]  free-list return valid
- fl_ret_preg  out  [2:0][PREG_W-1:0]  tag returned (told)
- sq_commit_cnt  out  2  stores committed this cycle (0-3)
- rec_enable  out  1  recovery pulse (registered)
- rec_pc  out  XLEN  redirect PC, valid with rec_enable
- halted  out  1  sticky halt flag
- commit_cnt  out  32  committed instruction counter
- mispred_cnt  out  32  recovery event counter

## Operation
- States: RUN, RECOVER, HALT. Reset -> RUN.
- RUN: scan slots 2,1,0. A slot commits if valid and every older valid slot in the cycle commits without being a truncation point. Truncation point: first committing slot with ret_halt or ret_precise; it commits itself, all younger slots are dropped (no output effects).
- Valid slots need not be contiguous; an invalid slot is skipped, not a stop.
- Per committing slot i: am_we[i]=1, fl_ret_valid[i]=1 unless ret_areg[i]==0 (both 0 then); am_areg/am_preg = ret_areg/ret_tag; fl_ret_preg = ret_told. Non-committing slots drive 0 on all per-slot outputs.
- sq_commit_cnt = count of committing slots with ret_is_store.
- Truncation by ret_precise (no halt in same slot): next state RECOVER, rec_pc <= ret_target of that slot.
- Truncation by ret_halt: next state HALT, halted <= 1. Halt outranks precise in the same slot.
- RECOVER: rec_enable=1 for exactly this cycle; all ret inputs ignored (no commits, all per-slot outputs 0, sq_commit_cnt 0); next state RUN.
- HALT: inputs ignored permanently; only rst leaves.

## Timing
- Commit outputs (am_*, fl_*, sq_commit_cnt) combinational from inputs in the same cycle as the retire packet.
- rec_enable, rec_pc, halted, counters registered; rec_enable rises the cycle after the mispredicted branch commits.
- Reset values: state RUN, rec_enable 0, rec_pc 0, halted 0, commit_cnt 0, mispred_cnt 0; all combinational outputs 0 while rst high.
- rec_pc holds its value after the pulse until the next recovery.
- Counters wrap modulo 2^32. commit_cnt adds the number of committing slots (including the truncating slot).
- rst during RECOVER: no pulse next cycle; state RUN.

## Configuration
- RT_COMMIT_CNT_EN defined: commit_cnt and mispred_cnt implemented as above; mispred_cnt increments by 1 on each RUN->RECOVER transition.
- Not defined: counter registers absent, commit_cnt and mispred_cnt tied to 0; all other behaviour identical.

## Test plan
- Reset, then ret_valid=3'b111, areg 1/2/3, tags 10/11/12, told 4/5/6 -> am_we=111, fl_ret_preg={6,5,4} order by slot, commit_cnt=3 next cycle.
- ret_valid=3'b111, slot 1 ret_precise=1, ret_target=0x1000 -> am_we=110, next cycle rec_enable=1, rec_pc=0x1000, mispred_cnt=1; retire packet in that cycle ignored; following cycle rec_enable=0.
- Slot 2 ret_halt=1, slots 1,0 valid -> am_we=100, halted=1 next cycle; later packets produce no commits until rst.
- ret_valid=3'b101, slot 0 areg=0, both stores -> am_we=100, fl_ret_valid=100, sq_commit_cnt=2.
- Assert rst in RECOVER cycle -> rec_enable 0 next cycle, all counters 0, state RUN.
- commit_cnt preloaded near 0xFFFFFFFF via 3-wide commits -> wraps to 1 or 2 correctly; with RT_COMMIT_CNT_EN undefined stays 0.

Source files
------------

// File: rtl/rt_commit_unit.sv
// Retire-side commit unit: in-order arch-map/free-list/store commits, mispredict recovery and halt.
// Optional RT_COMMIT_CNT_EN macro enables the commit_cnt/mispred_cnt counter registers.
module rt_commit_unit #(
    parameter int AREG_W = 5,
    parameter int PREG_W = 6,
    parameter int XLEN   = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [2:0]                   ret_valid,
    input  logic [2:0][AREG_W-1:0]       ret_areg,
    input  logic [2:0][PREG_W-1:0]       ret_tag,
    input  logic [2:0][PREG_W-1:0]       ret_told,
    input  logic [2:0]                   ret_is_store,
    input  logic [2:0]                   ret_halt,
    input  logic [2:0]                   ret_precise,
    input  logic [2:0][XLEN-1:0]         ret_target,
    output logic [2:0]                   am_we,
    output logic [2:0][AREG_W-1:0]       am_areg,
    output logic [2:0][PREG_W-1:0]       am_preg,
    output logic [2:0]                   fl_ret_valid,
    output logic [2:0][PREG_W-1:0]       fl_ret_preg,
    output logic [1:0]                   sq_commit_cnt,
    output logic                         rec_enable,
    output logic [XLEN-1:0]              rec_pc,
    output logic                         halted,
    output logic [31:0]                  commit_cnt,
    output logic [31:0]                  mispred_cnt
);

    typedef enum logic [1:0] {RUN, RECOVER, HALT} state_t;

    state_t            state;
    logic [2:0]        commit;
    logic              stop;
    logic              trunc_halt;
    logic              trunc_prec;
    logic [XLEN-1:0]   trunc_target;
    logic [1:0]        n_commit;
    logic [1:0]        sq_sum;

    // Oldest-first scan; the first halt/mispredict commits itself and blocks younger slots.
    always_comb begin
        commit       = '0;
        stop         = 1'b0;
        trunc_halt   = 1'b0;
        trunc_prec   = 1'b0;
        trunc_target = '0;
        n_commit     = '0;
        sq_sum       = '0;
        if (!rst && state == RUN) begin
            for (int i = 2; i >= 0; i--) begin
                if (!stop && ret_valid[i]) begin
                    commit[i] = 1'b1;
                    n_commit  = n_commit + 2'd1;
                    if (ret_is_store[i])
                        sq_sum = sq_sum + 2'd1;
                    if (ret_halt[i]) begin
                        stop       = 1'b1;
                        trunc_halt = 1'b1;
                    end else if (ret_precise[i]) begin
                        stop         = 1'b1;
                        trunc_prec   = 1'b1;
                        trunc_target = ret_target[i];
                    end
                end
            end
        end
    end

    // Writes to x0 commit for ordering/counting but touch neither map nor free list.
    always_comb begin
        am_we        = '0;
        am_areg      = '0;
        am_preg      = '0;
        fl_ret_valid = '0;
        fl_ret_preg  = '0;
        for (int i = 0; i < 3; i++) begin
            if (commit[i]) begin
                am_we[i]        = (ret_areg[i] != '0);
                fl_ret_valid[i] = (ret_areg[i] != '0);
                am_areg[i]      = ret_areg[i];
                am_preg[i]      = ret_tag[i];
                fl_ret_preg[i]  = ret_told[i];
            end
        end
        sq_commit_cnt = sq_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            rec_enable <= 1'b0;
            rec_pc     <= '0;
            halted     <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    rec_enable <= trunc_prec;
                    if (trunc_halt) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else if (trunc_prec) begin
                        state  <= RECOVER;
                        rec_pc <= trunc_target;
                    end
                end
                RECOVER: begin
                    rec_enable <= 1'b0;
                    state      <= RUN;
                end
                default: begin
                    rec_enable <= 1'b0;
                    state      <= HALT;
                end
            endcase
        end
    end

`ifdef RT_COMMIT_CNT_EN
    logic [31:0] commit_cnt_q;
    logic [31:0] mispred_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            commit_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            commit_cnt_q <= commit_cnt_q + 32'(n_commit);
            if (trunc_prec)
                mispred_cnt_q <= mispred_cnt_q + 32'd1;
        end
    end

    assign commit_cnt  = commit_cnt_q;
    assign mispred_cnt = mispred_cnt_q;
`else
    assign commit_cnt  = '0;
    assign mispred_cnt = '0;
`endif

endmodule
